// File: rtl/coproc_hps_bridge.sv
// HPS word-bus front-end for the matrix coprocessor: collects an instruction
// and operand words, runs the coprocessor, streams status and result back.
module coproc_hps_bridge #(
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [31:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic [2:0]   cp_op_code,
   output logic [1:0]   cp_matrix_size,
   output logic [7:0]   cp_scalar,
   output logic [199:0] cp_matrix_a,
   output logic [199:0] cp_matrix_b,
   input  logic [199:0] cp_result,
   input  logic         cp_overflow,
   input  logic         cp_done
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_M1    = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      EXEC,
      SEND
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [2:0]     wcnt;
   logic [CW-1:0]  ccnt;
   logic [2:0]     oidx;
   logic           err;
   logic           ovf;
   logic [199:0]   result;

   logic           xfer_in;
   logic           xfer_out;
   logic           last_w;
   logic           fin;
   logic           tmo;
   logic           last_o;
   logic           needs_b;
   logic [31:0]    status;
   logic [223:0]   rpad;
   logic [2:0]     sel;
   logic [31:0]    rword;

   // Word k lands in bits [32k+31:32k]; word 6 only fills the top byte.
   function automatic logic [199:0] put_word(
      input logic [199:0] m,
      input logic [2:0]   k,
      input logic [31:0]  d
   );
      logic [199:0] r;
      r = m;
      for (int i = 0; i < 6; i++) begin
         if (k == 3'(i)) r[32*i +: 32] = d;
      end
      if (k == 3'd6) r[199:192] = d[7:0];
      return r;
   endfunction

   assign in_ready  = (state == IDLE) || (state == LOAD_A) ||
                      (state == LOAD_B);
   assign out_valid = (state == SEND);
   assign busy      = (state != IDLE);

   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;
   assign last_w   = (wcnt == 3'd6);
   assign fin      = (ccnt >= SETTLE_M1) && cp_done;
   assign tmo      = (ccnt == TMO_M1);
   assign last_o   = err ? (oidx == 3'd0) : (oidx == 3'd7);
   assign needs_b  = (cp_op_code == 3'b000) || (cp_op_code == 3'b001) ||
                     (cp_op_code == 3'b010);

   assign status = {27'd0, cp_op_code, err, ovf};
   assign rpad   = {24'd0, result};
   assign sel    = oidx - 3'd1;
   assign rword  = 32'(rpad >> {sel, 5'b0});

   always_comb begin
      out_data = '0;
      if (state == SEND) out_data = (oidx == 3'd0) ? status : rword;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (xfer_in)
               state_nx = (in_data[2:0] == 3'b111) ? SEND : LOAD_A;
         end
         LOAD_A: begin
            if (xfer_in && last_w) state_nx = needs_b ? LOAD_B : EXEC;
         end
         LOAD_B: begin
            if (xfer_in && last_w) state_nx = EXEC;
         end
         EXEC: begin
            if (fin || tmo) state_nx = SEND;
         end
         SEND: begin
            if (xfer_out && last_o) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt           <= '0;
         ccnt           <= '0;
         oidx           <= '0;
         err            <= 1'b0;
         ovf            <= 1'b0;
         result         <= '0;
         cp_op_code     <= '0;
         cp_matrix_size <= '0;
         cp_scalar      <= '0;
         cp_matrix_a    <= '0;
         cp_matrix_b    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer_in) begin
                  cp_op_code     <= in_data[2:0];
                  cp_matrix_size <= in_data[4:3];
                  cp_scalar      <= in_data[12:5];
                  err            <= (in_data[2:0] == 3'b111);
                  ovf            <= 1'b0;
                  cp_matrix_b    <= '0;
                  wcnt           <= '0;
                  oidx           <= '0;
               end
            end
            LOAD_A: begin
               ccnt <= '0;
               if (xfer_in) begin
                  cp_matrix_a <= put_word(cp_matrix_a, wcnt, in_data);
                  wcnt        <= last_w ? 3'd0 : wcnt + 3'd1;
               end
            end
            LOAD_B: begin
               ccnt <= '0;
               if (xfer_in) begin
                  cp_matrix_b <= put_word(cp_matrix_b, wcnt, in_data);
                  wcnt        <= last_w ? 3'd0 : wcnt + 3'd1;
               end
            end
            EXEC: begin
               ccnt <= ccnt + 1'b1;
               if (fin) begin
                  result <= cp_result;
                  ovf    <= cp_overflow;
               end else if (tmo) begin
                  err    <= 1'b1;
                  result <= '0;
               end
            end
            SEND: begin
               if (xfer_out) oidx <= last_o ? 3'd0 : oidx + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_coproc_hps_bridge.sv
// Directed bench for coproc_hps_bridge: a bytewise-add coprocessor stub, a
// word-queue model of the response stream, and literal checks on key cases.
module tb_coproc_hps_bridge;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         busy;
   logic [2:0]   cp_op_code;
   logic [1:0]   cp_matrix_size;
   logic [7:0]   cp_scalar;
   logic [199:0] cp_matrix_a;
   logic [199:0] cp_matrix_b;
   logic [199:0] cp_result;
   logic         cp_overflow;
   logic         cp_done;

   logic         stub_done = 1'b1;
   logic         stub_ovf = 1'b0;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  wa[7];
   logic [31:0]  wb[7];
   logic         s_in_ready;
   logic         s_out_valid;

   coproc_hps_bridge dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .busy           (busy),
      .cp_op_code     (cp_op_code),
      .cp_matrix_size (cp_matrix_size),
      .cp_scalar      (cp_scalar),
      .cp_matrix_a    (cp_matrix_a),
      .cp_matrix_b    (cp_matrix_b),
      .cp_result      (cp_result),
      .cp_overflow    (cp_overflow),
      .cp_done        (cp_done)
   );

   always #5 clk = ~clk;

   // Coprocessor stub: bytewise A+B, overflow and done from bench knobs.
   always_comb begin
      cp_result = '0;
      for (int i = 0; i < 25; i++)
         cp_result[8*i +: 8] = cp_matrix_a[8*i +: 8] + cp_matrix_b[8*i +: 8];
   end
   assign cp_overflow = stub_ovf;
   assign cp_done     = stub_done;

   task automatic check(input string name, input logic [199:0] act,
                        input logic [199:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // One cycle: compare outputs at the negedge, then step past the posedge.
   task automatic tick();
      @(negedge clk);
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h want no word", out_data);
         end else begin
            check("out_word", {168'd0, out_data}, {168'd0, exp_q[0]});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         ok = s_in_ready;
      end
      in_valid = 1'b0;
      if (!ok) check("send_accept", 0, 1);
   endtask

   task automatic send_ops(input logic [2:0] op);
      if (op == 3'b111) return;
      for (int k = 0; k < 7; k++) send_word(wa[k]);
      if (op <= 3'b010)
         for (int k = 0; k < 7; k++) send_word(wb[k]);
   endtask

   task automatic drain(input int bp_word, input int bp_len);
      int total;
      int hold;
      total = exp_q.size();
      hold  = 0;
      for (int i = 0; i < 700 && exp_q.size() > 0; i++) begin
         if (total - exp_q.size() == bp_word && hold < bp_len) begin
            out_ready = 1'b0;
            hold++;
         end else begin
            out_ready = 1'b1;
         end
         tick();
      end
      out_ready = 1'b1;
      if (exp_q.size() != 0) check("drain_done", 0, 1);
   endtask

   // Response model: status word then the 200-bit bytewise sum in 7 words.
   task automatic model(input logic [2:0] op, input logic ovf,
                        input logic done);
      logic [199:0] va;
      logic [199:0] vb;
      logic [199:0] r;
      va = '0;
      vb = '0;
      for (int k = 0; k < 6; k++) begin
         va[32*k +: 32] = wa[k];
         vb[32*k +: 32] = wb[k];
      end
      va[199:192] = wa[6][7:0];
      vb[199:192] = wb[6][7:0];
      if (op > 3'b010) vb = '0;
      for (int i = 0; i < 25; i++) r[8*i +: 8] = va[8*i +: 8] + vb[8*i +: 8];
      if (op == 3'b111 || !done) begin
         exp_q.push_back({27'd0, op, 2'b10});
      end else begin
         exp_q.push_back({27'd0, op, 1'b0, ovf});
         for (int k = 0; k < 6; k++) exp_q.push_back(r[32*k +: 32]);
         exp_q.push_back({24'd0, r[199:192]});
      end
   endtask

   initial begin
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_cp_a", cp_matrix_a, 0);
      rst_n = 1'b1;
      tick();

      // Abandon a transfer in LOAD_B word 3
      for (int k = 0; k < 7; k++) begin
         wa[k] = 32'h1111_0000 + k;
         wb[k] = 32'h2222_0000 + k;
      end
      send_word(32'h0000_0000);
      for (int k = 0; k < 7; k++) send_word(wa[k]);
      for (int k = 0; k < 3; k++) send_word(wb[k]);
      check("midb_busy", busy, 1);
      in_data  = wb[3];
      in_valid = 1'b1;
      rst_n    = 1'b0;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_cp_a", cp_matrix_a, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();

      // Add path with literal expectations and latency check
      for (int k = 0; k < 6; k++) begin
         wa[k] = 32'h0101_0101;
         wb[k] = 32'h0202_0202;
      end
      wa[6] = 32'h0000_0001;
      wb[6] = 32'h0000_0002;
      exp_q.push_back(32'h0000_0000);
      for (int k = 0; k < 6; k++) exp_q.push_back(32'h0303_0303);
      exp_q.push_back(32'h0000_0003);
      send_word(32'h0000_0008);
      check("add_size", cp_matrix_size, 2'b01);
      send_ops(3'b000);
      tick();
      check("lat_edge1", s_out_valid, 0);
      tick();
      check("lat_edge2", s_out_valid, 0);
      tick();
      check("lat_valid", s_out_valid, 1);
      drain(-1, 0);

      // Single-operand op 101, ignored upper instruction bits set
      for (int k = 0; k < 7; k++) wa[k] = 32'hA5C3_0F00 + 32'(k * 3);
      model(3'b101, 1'b0, 1'b1);
      send_word(32'hFFFF_F035);
      send_ops(3'b101);
      tick();
      check("single_in_ready", s_in_ready, 0);
      check("single_cp_b", cp_matrix_b, 0);
      check("single_op", cp_op_code, 3'b101);
      check("single_scalar", cp_scalar, 8'h81);
      check("single_size", cp_matrix_size, 2'b10);
      drain(-1, 0);

      // Invalid op: one status word only
      exp_q.push_back(32'h0000_001E);
      send_word(32'h0000_0007);
      drain(-1, 0);
      check("inv_idle", busy, 0);

      // Timeout: op 100 with done never asserted
      stub_done = 1'b0;
      for (int k = 0; k < 7; k++) wa[k] = 32'h7777_0000 | k;
      model(3'b100, 1'b0, 1'b0);
      send_word(32'h0000_0004);
      send_ops(3'b100);
      drain(-1, 0);
      check("tmo_idle", busy, 0);
      stub_done = 1'b1;

      // Backpressure on word 2 with overflow flagged
      stub_ovf = 1'b1;
      for (int k = 0; k < 7; k++) begin
         wa[k] = 32'hFF80_7F01 + 32'(k * 32'h0101_0101);
         wb[k] = 32'h0180_8002 + 32'(k);
      end
      model(3'b010, 1'b1, 1'b1);
      send_word(32'h0000_0002);
      send_ops(3'b010);
      drain(2, 5);
      stub_ovf = 1'b0;
      tick();
      check("end_busy", busy, 0);
      check("end_in_ready", in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/coproc_hps_bridge.md
Name: coproc_hps_bridge

Overview:
- Command front-end that sits between the HPS word bus and the matrix coprocessor.
- Accepts a 32-bit instruction word from the HPS, then the operand words for matrix A and, when the op needs it, matrix B.
- Drives the coprocessor operand/op_code inputs, waits for process_Done, captures result_final and overflow.
- Returns a status word and the 200-bit result, serialized as 32-bit words, over a ready/valid output channel.

Parameters:
- SETTLE_CYCLES, 2, minimum cycles operands are held stable before the result is sampled; range 1..15.
- TIMEOUT_CYCLES, 255, maximum cycles spent in EXEC waiting for process_Done before an error is reported; must be greater than SETTLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  32  instruction/operand word from HPS.
- in_valid  in  1  in_data valid.
- in_ready  out  1  bridge accepts in_data; a transfer occurs when in_valid and in_ready are both high at a rising edge.
- out_data  out  32  status/result word to HPS.
- out_valid  out  1  out_data valid.
- out_ready  in  1  HPS accepts out_data.
- busy  out  1  high in every state except IDLE.
- cp_op_code  out  3  to coprocessor op_code.
- cp_matrix_size  out  2  to coprocessor matrix_size.
- cp_scalar  out  8  to coprocessor scalar (signed).
- cp_matrix_a  out  200  to coprocessor matrix_a.
- cp_matrix_b  out  200  to coprocessor matrix_b.
- cp_result  in  200  from coprocessor result_final.
- cp_overflow  in  1  from coprocessor overflow.
- cp_done  in  1  from coprocessor process_Done.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0. All cp_* outputs, the result register and the status register are 0. Reset is asynchronous from any state and abandons any transfer in progress.
- Instruction word fields: [2:0] op, [4:3] size, [12:5] scalar, [31:13] ignored.
- Op 111 is invalid. The bridge latches error=1, skips loading and EXEC, and goes straight to SEND with a 1-word response.
- Operand packing: 7 words per matrix. Word k (k=0..6) carries bits [32k+31:32k]. Word 6 uses only in_data[7:0] for bits [199:192]; in_data[31:8] is ignored.
- IDLE: in_ready=1. On transfer, latch op/size/scalar, clear error, then go to LOAD_A, or to SEND if op=111.
- LOAD_A: in_ready=1. Word counter runs 0..6. After word 6 is accepted: ops 000, 001, 010 go to LOAD_B; ops 011, 100, 101, 110 go to EXEC with cp_matrix_b=0.
- LOAD_B: same as LOAD_A, writing B; after word 6, go to EXEC.
- Operand registers are written only on transfers. cp_* outputs are registered and change only in IDLE/LOAD states.
- EXEC: in_ready=0 and a cycle counter starts at 0 on entry.
  - When counter ≥ SETTLE_CYCLES−1 and cp_done=1: capture cp_result and cp_overflow, go to SEND.
  - If counter reaches TIMEOUT_CYCLES−1 without that: set error=1, result=0, go to SEND.
- With SETTLE_CYCLES=2 and cp_done held high, out_valid rises 2 edges after the edge that accepted the last operand word.
- SEND: out_valid=1 and out_data is held stable until out_ready.
  - Word 0 is the status word: [0] overflow, [1] error, [4:2] op, [31:5] 0.
  - Words 1..7 are result bits [32(k−1)+31 : 32(k−1)]. Word 7 carries result[199:192] in [7:0], zero-extended.
  - With error=1 only the status word is sent.
  - After the last word handshake: out_valid=0, return to IDLE.
- in_valid during EXEC/SEND is ignored (in_ready=0) and no word is lost from the HPS side.
- out_ready while out_valid=0 has no effect.
- A new instruction can be accepted the cycle after the final output handshake.

Test Plan:
- Reset: hold rst_n=0 mid-LOAD_B (word 3) → next cycle state IDLE, busy=0, in_ready=1, out_valid=0, cp_matrix_a=0.
- Add path: instr op=000, size=01. A words 0x01010101 ×6 + 0x01, B all 0x02020202 ×6 + 0x02. Stub returns A+B bytewise with overflow=0. → status 0x00000000, then 6 words 0x03030303 and a last word 0x00000003.
- Single-operand path: op=101 → exactly 7 operand words accepted and in_ready drops after the 7th; cp_matrix_b=0; status [4:2]=101.
- Invalid op: instr 0x00000007 → single status word 0x0000001E, then IDLE; no operand words accepted as operands.
- Timeout: op=100 with stub cp_done=0 → after 255 EXEC cycles the status error=1, then IDLE.
- Backpressure: out_ready low for 5 cycles on word 2 → out_data stable and no word skipped; overflow=1 from the stub gives status bit0=1.
